// File: rtl/wb_queue_2w.sv
// wb_queue_2w: dual-issue writeback queue feeding a two-write-port RAM.
// Up to two results enter per cycle and up to two leave per cycle, in order.
// The younger drained entry always goes out on port 2, so a same-address
// pair resolves in program order at the RAM.
// DEPTH must be a power of two and at least 4 so that pointer wrap is free
// and a dual drain always fits in the pointer width.

`ifndef ADDR_LEN
`define ADDR_LEN 8
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module wb_queue_2w #(
  parameter int BRAM_ADDR_WIDTH = `ADDR_LEN,
  parameter int BRAM_DATA_WIDTH = `DATA_LEN,
  parameter int DEPTH           = 8
) (
  input  logic                       clk,
  input  logic                       reset_x,
  input  logic                       in0_valid,
  input  logic [BRAM_ADDR_WIDTH-1:0] in0_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] in0_data,
  input  logic                       in1_valid,
  input  logic [BRAM_ADDR_WIDTH-1:0] in1_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] in1_data,
  output logic                       in_ready,
  input  logic                       drain_en,
  output logic                       we1,
  output logic [BRAM_ADDR_WIDTH-1:0] waddr1,
  output logic [BRAM_DATA_WIDTH-1:0] wdata1,
  output logic                       we2,
  output logic [BRAM_ADDR_WIDTH-1:0] waddr2,
  output logic [BRAM_DATA_WIDTH-1:0] wdata2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [BRAM_ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [BRAM_DATA_WIDTH-1:0] mem_data [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [PW-1:0] slot1;
  logic          accept0;
  logic          accept1;
  logic [CW-1:0] n_in;
  logic [CW-1:0] n_out;

  // Acceptance and drain decisions, all derived from registered state so
  // freed slots from a same-cycle drain never widen in_ready.
  always_comb begin
    in_ready = (count <= CW'(DEPTH - 2));
    accept0  = in_ready && in0_valid;
    accept1  = in_ready && in1_valid;
    head_p1  = head + 1'b1;
    tail_p1  = tail + 1'b1;
    slot1    = in0_valid ? tail_p1 : tail;
    we1      = drain_en && (count != '0);
    we2      = drain_en && (count >= CW'(2));
    n_in     = {{(CW-1){1'b0}}, accept0} + {{(CW-1){1'b0}}, accept1};
    n_out    = {{(CW-1){1'b0}}, we1} + {{(CW-1){1'b0}}, we2};
    empty    = (count == '0);
    waddr1   = mem_addr[head];
    wdata1   = mem_data[head];
    waddr2   = mem_addr[head_p1];
    wdata2   = mem_data[head_p1];
  end

  // Entry storage is deliberately left unreset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (accept0) begin
      mem_addr[tail] <= in0_addr;
      mem_data[tail] <= in0_data;
    end
    if (accept1) begin
      mem_addr[slot1] <= in1_addr;
      mem_data[slot1] <= in1_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset empties the queue at once.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_out[PW-1:0];
      tail  <= tail + n_in[PW-1:0];
      count <= count + n_in - n_out;
    end
  end

endmodule
